// File: rtl/sim_monitor_pkg.sv
// Shared definitions for the simulation monitor: default geometry, trace-entry layout
// and the distances of the halt/config addresses below the top of the address space.
package sim_monitor_pkg;

    localparam int unsigned DEF_AW        = 24;
    localparam int unsigned DEF_DW        = 32;
    localparam int unsigned DEF_NWATCH    = 4;
    localparam int unsigned DEF_TRC_DEPTH = 16;
    localparam int unsigned DEF_CYC_W     = 32;

    // Watch index field is wide enough for the 8-watchpoint maximum.
    localparam int unsigned IDX_W = 3;

    // Default HALT_ADDR is all-ones; the config window starts 15 words below it.
    localparam int unsigned HALT_OFS_DEF = 0;
    localparam int unsigned CFG_OFS_DEF  = 15;

    // Trace entry layout, MSB to LSB: {watch index, address, data, cycle}.
    function automatic int unsigned trc_w(input int unsigned aw, input int unsigned dw,
                                          input int unsigned cw);
        return IDX_W + aw + dw + cw;
    endfunction

    function automatic int unsigned trc_data_lsb(input int unsigned cw);
        return cw;
    endfunction

    function automatic int unsigned trc_addr_lsb(input int unsigned dw, input int unsigned cw);
        return dw + cw;
    endfunction

    function automatic int unsigned trc_idx_lsb(input int unsigned aw, input int unsigned dw,
                                                input int unsigned cw);
        return aw + dw + cw;
    endfunction

endpackage

// File: rtl/sim_monitor_fifo.sv
// Trace FIFO: power-of-two depth, pointers carry one extra wrap bit for full/empty.
// Output side is valid/ready; a push while full is accepted only alongside a pop.
module sim_monitor_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop, push_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign o_valid = ~o_empty;
    assign o_data  = o_valid ? mem_q[rd_ptr_q[PW-1:0]] : '0;

    assign pop     = o_valid & i_ready;
    // Full-and-pop frees the head slot on the same edge, so the push may land there.
    assign push_ok = i_push & (~o_full | pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sim_monitor.sv
// Bus-snooping simulation monitor: cycle counter, halt request, write watchpoints with trace.
// Trace FIFO present only when SIM_MONITOR_TRACE_EN is defined; otherwise trace outputs read 0.
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned   AW        = DEF_AW,
    parameter int unsigned   DW        = DEF_DW,
    parameter int unsigned   NWATCH    = DEF_NWATCH,
    parameter int unsigned   TRC_DEPTH = DEF_TRC_DEPTH,
    parameter int unsigned   CYC_W     = DEF_CYC_W,
    parameter logic [AW-1:0] HALT_ADDR = {AW{1'b1}} - AW'(HALT_OFS_DEF),
    parameter logic [AW-1:0] CFG_BASE  = {AW{1'b1}} - AW'(CFG_OFS_DEF)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_clk_en,
    input  logic [AW-1:0]                    i_daddr,
    input  logic [DW-1:0]                    i_ddata,
    input  logic                             i_wr,
    output logic                             o_halt,
    output logic [7:0]                       o_halt_code,
    output logic [CYC_W-1:0]                 o_cycle,
    output logic                             o_cyc_ovf,
    output logic [NWATCH-1:0]                o_watch_hit,
    output logic                             o_trc_valid,
    input  logic                             i_trc_ready,
    output logic [trc_w(AW,DW,CYC_W)-1:0]    o_trc_data,
    output logic                             o_trc_ovf
);

    localparam int unsigned TW = trc_w(AW, DW, CYC_W);

    logic              halt_q;
    logic [7:0]        halt_code_q;
    logic [CYC_W-1:0]  cycle_q;
    logic              cyc_ovf_q;
    logic [NWATCH-1:0] armed_q, hit_q;
    logic [AW-1:0]     waddr_q [NWATCH];

    logic              wr_ev;
    logic [NWATCH-1:0] cfg_sel, hit_d;
    logic [IDX_W-1:0]  hit_idx;

    // Every write-driven effect is blocked once halted.
    assign wr_ev = i_clk_en & i_wr & ~halt_q;

    always_comb begin
        cfg_sel = '0;
        hit_d   = '0;
        hit_idx = '0;
        for (int unsigned k = 0; k < NWATCH; k++) begin
            cfg_sel[k] = wr_ev && (i_daddr == CFG_BASE + AW'(k));
        end
        for (int unsigned k = 0; k < NWATCH; k++) begin
            hit_d[k] = wr_ev && ~|cfg_sel && armed_q[k] && (waddr_q[k] == i_daddr);
        end
        for (int unsigned k = NWATCH; k > 0; k--) begin
            if (hit_d[k-1]) hit_idx = IDX_W'(k-1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            cycle_q     <= '0;
            cyc_ovf_q   <= 1'b0;
            armed_q     <= '0;
            hit_q       <= '0;
            for (int unsigned k = 0; k < NWATCH; k++) waddr_q[k] <= '0;
        end else begin
            // Pulses clear on any edge; hit_d is already zero when not enabled.
            hit_q <= hit_d;
            if (i_clk_en) begin
                if (!halt_q) begin
                    cycle_q <= cycle_q + CYC_W'(1);
                    if (&cycle_q) cyc_ovf_q <= 1'b1;
                end
                if (wr_ev && (i_daddr == HALT_ADDR)) begin
                    halt_q      <= 1'b1;
                    halt_code_q <= i_ddata[7:0];
                end
                for (int unsigned k = 0; k < NWATCH; k++) begin
                    if (cfg_sel[k]) begin
                        waddr_q[k] <= i_ddata[AW-1:0];
                        armed_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_halt      = halt_q;
    assign o_halt_code = halt_code_q;
    assign o_cycle     = cycle_q;
    assign o_cyc_ovf   = cyc_ovf_q;
    assign o_watch_hit = hit_q;

`ifdef SIM_MONITOR_TRACE_EN
    logic [TW-1:0] trc_entry;
    logic          fifo_full, fifo_empty, trc_push, trc_pop, trc_ovf_q;

    assign trc_entry = {hit_idx, i_daddr, i_ddata, cycle_q};
    assign trc_push  = |hit_d;
    assign trc_pop   = ~fifo_empty & i_trc_ready;

    sim_monitor_fifo #(
        .WIDTH (TW),
        .DEPTH (TRC_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (trc_push),
        .i_data  (trc_entry),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_valid (o_trc_valid),
        .o_data  (o_trc_data),
        .i_ready (i_trc_ready)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                              trc_ovf_q <= 1'b0;
        else if (trc_push & fifo_full & ~trc_pop) trc_ovf_q <= 1'b1;
    end

    assign o_trc_ovf = trc_ovf_q;
`else
    logic                         unused_trc;
    logic [$clog2(TRC_DEPTH):0]   unused_depth;

    assign unused_trc   = ^{i_trc_ready, hit_idx};
    assign unused_depth = '0;
    assign o_trc_valid  = 1'b0;
    assign o_trc_ovf    = 1'b0;
    assign o_trc_data   = '0;
`endif

endmodule

// File: tb/tb_sim_monitor.sv
// Self-checking bench for sim_monitor: queue-based reference model compared every cycle,
// plus literal checks. Trace expectations follow SIM_MONITOR_TRACE_EN.
`timescale 1ns/1ps
module tb_sim_monitor;
    import sim_monitor_pkg::*;

    localparam int unsigned AW = 24, DW = 32, NW = 4, DEPTH = 16, CW = 32;
    localparam int unsigned TW = 3 + AW + DW + CW;
    localparam logic [AW-1:0] HALT_A = 24'hFFFFFF;
    localparam logic [AW-1:0] CFG_A  = 24'hFFFFF0;
    localparam int unsigned STW = 3 + AW + DW + 4;

    logic          clk = 1'b0, rst = 1'b1, ce = 1'b0, wr = 1'b0, rdy = 1'b0, ce_s = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;

    logic          o_halt, o_cyc_ovf, o_trc_valid, o_trc_ovf;
    logic [7:0]    o_halt_code;
    logic [CW-1:0] o_cycle;
    logic [NW-1:0] o_watch_hit;
    logic [TW-1:0] o_trc_data;

    logic           s_halt, s_cyc_ovf, s_trc_valid, s_trc_ovf;
    logic [7:0]     s_halt_code;
    logic [3:0]     s_cycle;
    logic [0:0]     s_watch_hit;
    logic [STW-1:0] s_trc_data;

    int n_cmp = 0, n_err = 0;
    int nstep = 0;
    bit cmp_on = 0;

    always #5 clk = ~clk;

    sim_monitor u_dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(ce), .i_daddr(addr), .i_ddata(data), .i_wr(wr),
        .o_halt(o_halt), .o_halt_code(o_halt_code), .o_cycle(o_cycle), .o_cyc_ovf(o_cyc_ovf),
        .o_watch_hit(o_watch_hit), .o_trc_valid(o_trc_valid), .i_trc_ready(rdy),
        .o_trc_data(o_trc_data), .o_trc_ovf(o_trc_ovf)
    );

    sim_monitor #(.NWATCH(1), .TRC_DEPTH(2), .CYC_W(4)) u_small (
        .i_clk(clk), .i_rst(rst), .i_clk_en(ce_s), .i_daddr('0), .i_ddata('0), .i_wr(1'b0),
        .o_halt(s_halt), .o_halt_code(s_halt_code), .o_cycle(s_cycle), .o_cyc_ovf(s_cyc_ovf),
        .o_watch_hit(s_watch_hit), .o_trc_valid(s_trc_valid), .i_trc_ready(1'b0),
        .o_trc_data(s_trc_data), .o_trc_ovf(s_trc_ovf)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: spec-level state with the trace FIFO as a bounded queue.
    logic [CW-1:0] m_cycle;
    logic          m_cyc_ovf, m_halt, m_trc_ovf;
    logic [7:0]    m_code;
    logic [NW-1:0] m_armed, m_hit;
    logic [AW-1:0] m_waddr [NW];
    logic [TW-1:0] m_q [$];

    always @(posedge clk or posedge rst) begin : model
        logic [NW-1:0] hits;
        logic [2:0]    first;
        logic [AW-1:0] ofs;
        bit            is_cfg, do_pop, halted;
        if (rst) begin
            m_cycle = '0; m_cyc_ovf = 0; m_halt = 0; m_trc_ovf = 0; m_code = '0;
            m_armed = '0; m_hit = '0;
            for (int k = 0; k < NW; k++) m_waddr[k] = '0;
            m_q.delete();
        end else begin
            hits = '0; first = '0; is_cfg = 0; halted = m_halt;
            do_pop = (m_q.size() > 0) && rdy;
            if (ce && wr && !halted) begin
                is_cfg = (addr >= CFG_A) && ({8'd0, addr} < {8'd0, CFG_A} + NW);
                if (!is_cfg)
                    for (int k = 0; k < NW; k++)
                        if (m_armed[k] && m_waddr[k] == addr) hits[k] = 1'b1;
            end
            for (int k = NW - 1; k >= 0; k--) if (hits[k]) first = 3'(k);
`ifdef SIM_MONITOR_TRACE_EN
            if (do_pop) void'(m_q.pop_front());
            if (hits != '0) begin
                if (m_q.size() < DEPTH) m_q.push_back({first, addr, data, m_cycle});
                else m_trc_ovf = 1;
            end
`endif
            if (is_cfg) begin
                ofs = addr - CFG_A;
                m_waddr[ofs[1:0]] = data[AW-1:0];
                m_armed[ofs[1:0]] = 1'b1;
            end
            if (ce && wr && !halted && addr == HALT_A) begin
                m_halt = 1; m_code = data[7:0];
            end
            if (ce && !halted) begin
                m_cycle = m_cycle + 32'd1;
                if (m_cycle == '0) m_cyc_ovf = 1;
            end
            m_hit = hits;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cycle",   128'(o_cycle),     128'(m_cycle));
            check("cyc_ovf", 128'(o_cyc_ovf),   128'(m_cyc_ovf));
            check("halt",    128'(o_halt),      128'(m_halt));
            check("code",    128'(o_halt_code), 128'(m_code));
            check("hit",     128'(o_watch_hit), 128'(m_hit));
            check("valid",   128'(o_trc_valid), 128'(m_q.size() > 0));
            check("trc_ovf", 128'(o_trc_ovf),   128'(m_trc_ovf));
`ifdef SIM_MONITOR_TRACE_EN
            if (m_q.size() > 0) check("trc_data", 128'(o_trc_data), 128'(m_q[0]));
`else
            check("trc_data_zero", 128'(o_trc_data), 128'd0);
`endif
        end
    end

    task automatic step(input bit e, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit r);
        ce = e; wr = w; addr = a; data = d; rdy = r;
        @(posedge clk); #1;
        if (e) nstep++;
        wr = 0;
    endtask

    int frozen;

    initial begin
        @(posedge clk); #1 cmp_on = 1;
        @(posedge clk); #1 rst = 0;
        check("rst_cycle", 128'(o_cycle), 128'd0);
        check("rst_halt",  128'(o_halt), 128'd0);
        check("rst_valid", 128'(o_trc_valid), 128'd0);

        for (int i = 0; i < 20; i++) begin
            ce_s = !(i == 3 || i == 7 || i == 11 || i == 15);
            if (i == 10) step(1, 1, CFG_A + 24'd1, 32'h0000_0100, 0);
            else         step(1, 0, '0, '0, 0);
            if (i == 9) begin
                check("cyc10",       128'(o_cycle), 128'd10);
                check("cyc10_halt",  128'(o_halt), 128'd0);
                check("cyc10_valid", 128'(o_trc_valid), 128'd0);
            end
            if (i == 14) begin
                check("small_cyc12", 128'(s_cycle), 128'd12);
                check("small_ovf0",  128'(s_cyc_ovf), 128'd0);
            end
        end
        ce_s = 0;
        check("small_wrap", 128'(s_cycle), 128'd0);
        check("small_ovf1", 128'(s_cyc_ovf), 128'd1);

        step(1, 1, 24'h000100, 32'hDEADBEEF, 0);
        check("hit_w1", 128'(o_watch_hit), 128'h2);
`ifdef SIM_MONITOR_TRACE_EN
        check("trc_valid_w1", 128'(o_trc_valid), 128'd1);
        check("trc_entry_w1", 128'(o_trc_data), {37'd0, 3'd1, 24'h000100, 32'hDEADBEEF, 32'd20});
`endif
        step(1, 0, '0, '0, 0);
        check("hit_pulse_end", 128'(o_watch_hit), 128'h0);
        step(1, 0, '0, '0, 1);
        check("drained_w1", 128'(o_trc_valid), 128'd0);

        step(1, 1, CFG_A, 32'h0000_0200, 1);
        step(1, 1, CFG_A + 24'd2, 32'h0000_0200, 1);
        step(1, 1, 24'h000200, 32'h0000_0011, 1);
        check("multi_hit", 128'(o_watch_hit), 128'h5);
`ifdef SIM_MONITOR_TRACE_EN
        check("multi_idx", 128'(o_trc_data[trc_idx_lsb(AW, DW, CW) +: 3]), 128'd0);
`endif
        step(1, 0, '0, '0, 1);

        for (int i = 0; i < 17; i++) step(1, 1, 24'h000100, 32'(i), 0);
`ifdef SIM_MONITOR_TRACE_EN
        check("trc_ovf_set", 128'(o_trc_ovf), 128'd1);
        check("head_data0", 128'(o_trc_data[trc_data_lsb(CW) +: DW]), 128'd0);
`else
        check("trc_ovf_off", 128'(o_trc_ovf), 128'd0);
`endif
        step(1, 1, 24'h000100, 32'hAAAA_0000, 1);
`ifdef SIM_MONITOR_TRACE_EN
        check("head_data1", 128'(o_trc_data[trc_data_lsb(CW) +: DW]), 128'd1);
`endif
        for (int i = 0; i < 18; i++) step(1, 0, '0, '0, 1);
        check("drained_full", 128'(o_trc_valid), 128'd0);

        step(1, 1, 24'h000100, 32'h55, 0);
        step(1, 1, HALT_A, 32'h0000_002A, 0);
        frozen = nstep;
        check("halt_set",  128'(o_halt), 128'd1);
        check("halt_code", 128'(o_halt_code), 128'h2A);
        step(1, 1, HALT_A, 32'h0000_0077, 0);
        step(1, 1, CFG_A + 24'd3, 32'h0000_0100, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 24'h000100, 32'h66, 0);
            check("halt_no_hit", 128'(o_watch_hit), 128'h0);
        end
        check("halt_frozen", 128'(o_cycle), 128'(frozen));
        check("halt_code_kept", 128'(o_halt_code), 128'h2A);
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 1);
        check("halt_drained", 128'(o_trc_valid), 128'd0);

        rst = 1; nstep = 0;
        #1 check("rst2_halt", 128'(o_halt), 128'd0);
        @(posedge clk); #1 rst = 0;
        step(1, 1, CFG_A + 24'd1, 32'h0000_0100, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 24'h000100, 32'(i + 100), 0);
        #2 rst = 1; nstep = 0;
        #1;
        check("arst_halt",  128'(o_halt), 128'd0);
        check("arst_code",  128'(o_halt_code), 128'd0);
        check("arst_cycle", 128'(o_cycle), 128'd0);
        check("arst_covf",  128'(o_cyc_ovf), 128'd0);
        check("arst_hit",   128'(o_watch_hit), 128'd0);
        check("arst_valid", 128'(o_trc_valid), 128'd0);
        check("arst_tovf",  128'(o_trc_ovf), 128'd0);
        check("arst_data",  128'(o_trc_data), 128'd0);
        @(posedge clk); #1 rst = 0;
        step(1, 0, '0, '0, 1);
        check("first_count", 128'(o_cycle), 128'd1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, '0, '0, 1);
            check("post_rst_valid", 128'(o_trc_valid), 128'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
